tablero_ctrl: RTL and testbench

- Game controller for the 8x8 cell board shown by the screen painter.
- Owns the per-cell 4-bit state array, the cursor position and the win/lose flags, and sequences player actions against a loaded mine map.
- Reveal computes the adjacent-mine count sequentially, checking one neighbour per cycle.
- Outputs drive the painter directly: `states`, `state`, `win`, `lose`.

---
 rtl/tablero_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_tablero_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tablero_ctrl.sv
// 8x8 board game controller: owns the cell codes, cursor and result flags, and
// sequences reveal (neighbour count, one per cycle) and the mine-show sweep.
module tablero_ctrl #(
    parameter bit MOVE_WRAP = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [63:0]      i_mines,
    input  logic             i_up,
    input  logic             i_down,
    input  logic             i_left,
    input  logic             i_right,
    input  logic             i_reveal,
    input  logic             i_flag,
    output logic [63:0][3:0] o_states,
    output logic [3:0]       o_state,
    output logic [5:0]       o_cursor,
    output logic             o_busy,
    output logic             o_win,
    output logic             o_lose
);

    typedef enum logic [2:0] {
        S_IDLE, S_PLAY, S_COUNT, S_WRITE, S_SHOW, S_WIN, S_LOSE
    } state_t;

    localparam logic [3:0] C_HIDDEN = 4'd9;
    localparam logic [3:0] C_FLAG   = 4'd10;
    localparam logic [3:0] C_BOOM   = 4'd11;
    localparam logic [3:0] C_SHOWN  = 4'd12;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [63:0][3:0] r_cells;
    logic [63:0]      r_mines;
    logic [6:0]       r_mine_total;
    logic [6:0]       r_revealed;
    logic [5:0]       r_cursor;
    logic [5:0]       r_target;
    logic [2:0]       r_nbr;
    logic [3:0]       r_cnt;
    logic [5:0]       r_scan;
    logic             r_win;
    logic             r_lose;

    logic [6:0]       w_popcnt;
    logic [3:0]       w_cur_code;
    logic             w_do_reveal;
    logic             w_do_flag;
    logic             w_last_safe;
    logic [3:0]       w_dr;
    logic [3:0]       w_dc;
    logic [3:0]       w_nr;
    logic [3:0]       w_nc;
    logic             w_nbr_mine;
    logic [2:0]       w_row_nxt;
    logic [2:0]       w_col_nxt;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < 64; i++)
            w_popcnt = w_popcnt + {6'd0, i_mines[i]};
    end

    assign w_cur_code  = r_cells[r_cursor];
    assign w_do_reveal = (r_state == S_PLAY) && i_reveal && (w_cur_code == C_HIDDEN);
    assign w_do_flag   = (r_state == S_PLAY) && !i_reveal && i_flag &&
                         ((w_cur_code == C_HIDDEN) || (w_cur_code == C_FLAG));
    assign w_last_safe = (r_revealed + 7'd1) == (7'd64 - r_mine_total);

    // Offsets in 4-bit two's complement; bit 3 of the sum flags off-board
    always_comb begin
        w_dr = 4'd0;
        w_dc = 4'd0;
        case (r_nbr)
            3'd0:    begin w_dr = 4'hF; w_dc = 4'hF; end
            3'd1:    begin w_dr = 4'hF; w_dc = 4'h0; end
            3'd2:    begin w_dr = 4'hF; w_dc = 4'h1; end
            3'd3:    begin w_dr = 4'h0; w_dc = 4'hF; end
            3'd4:    begin w_dr = 4'h0; w_dc = 4'h1; end
            3'd5:    begin w_dr = 4'h1; w_dc = 4'hF; end
            3'd6:    begin w_dr = 4'h1; w_dc = 4'h0; end
            default: begin w_dr = 4'h1; w_dc = 4'h1; end
        endcase
    end

    assign w_nr       = {1'b0, r_target[5:3]} + w_dr;
    assign w_nc       = {1'b0, r_target[2:0]} + w_dc;
    assign w_nbr_mine = !w_nr[3] && !w_nc[3] && r_mines[{w_nr[2:0], w_nc[2:0]}];

    always_comb begin
        w_row_nxt = r_cursor[5:3];
        w_col_nxt = r_cursor[2:0];
        if (i_up)
            w_row_nxt = (r_cursor[5:3] == 3'd0) ? (MOVE_WRAP ? 3'd7 : 3'd0) : r_cursor[5:3] - 3'd1;
        else if (i_down)
            w_row_nxt = (r_cursor[5:3] == 3'd7) ? (MOVE_WRAP ? 3'd0 : 3'd7) : r_cursor[5:3] + 3'd1;
        if (i_left)
            w_col_nxt = (r_cursor[2:0] == 3'd0) ? (MOVE_WRAP ? 3'd7 : 3'd0) : r_cursor[2:0] - 3'd1;
        else if (i_right)
            w_col_nxt = (r_cursor[2:0] == 3'd7) ? (MOVE_WRAP ? 3'd0 : 3'd7) : r_cursor[2:0] + 3'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_start) begin
            w_state_nxt = (w_popcnt == 7'd64) ? S_WIN : S_PLAY;
        end else begin
            case (r_state)
                S_PLAY:  if (w_do_reveal) w_state_nxt = r_mines[r_cursor] ? S_SHOW : S_COUNT;
                S_COUNT: if (r_nbr == 3'd7) w_state_nxt = S_WRITE;
                S_WRITE: w_state_nxt = w_last_safe ? S_WIN : S_PLAY;
                S_SHOW:  if (r_scan == 6'd63) w_state_nxt = S_LOSE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        o_busy = (r_state == S_COUNT) || (r_state == S_WRITE) || (r_state == S_SHOW);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cells      <= {64{C_HIDDEN}};
            r_mines      <= '0;
            r_mine_total <= '0;
            r_revealed   <= '0;
            r_cursor     <= '0;
            r_target     <= '0;
            r_nbr        <= '0;
            r_cnt        <= '0;
            r_scan       <= '0;
            r_win        <= 1'b0;
            r_lose       <= 1'b0;
        end else if (i_start) begin
            r_cells      <= {64{C_HIDDEN}};
            r_mines      <= i_mines;
            r_mine_total <= w_popcnt;
            r_revealed   <= '0;
            r_cursor     <= '0;
            r_nbr        <= '0;
            r_cnt        <= '0;
            r_scan       <= '0;
            r_win        <= (w_popcnt == 7'd64);
            r_lose       <= 1'b0;
        end else begin
            case (r_state)
                S_PLAY: begin
                    r_cursor <= {w_row_nxt, w_col_nxt};
                    if (w_do_reveal) begin
                        r_target <= r_cursor;
                        r_nbr    <= '0;
                        r_cnt    <= '0;
                        r_scan   <= '0;
                        if (r_mines[r_cursor])
                            r_cells[r_cursor] <= C_BOOM;
                    end else if (w_do_flag) begin
                        r_cells[r_cursor] <= (w_cur_code == C_HIDDEN) ? C_FLAG : C_HIDDEN;
                    end
                end
                S_COUNT: begin
                    r_cnt <= r_cnt + {3'd0, w_nbr_mine};
                    r_nbr <= r_nbr + 3'd1;
                end
                S_WRITE: begin
                    r_cells[r_target] <= r_cnt;
                    r_revealed        <= r_revealed + 7'd1;
                    if (w_last_safe)
                        r_win <= 1'b1;
                end
                S_SHOW: begin
                    if (r_mines[r_scan] &&
                        ((r_cells[r_scan] == C_HIDDEN) || (r_cells[r_scan] == C_FLAG)))
                        r_cells[r_scan] <= C_SHOWN;
                    r_scan <= r_scan + 6'd1;
                    if (r_scan == 6'd63)
                        r_lose <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_states = r_cells;
    assign o_state  = r_cells[r_cursor];
    assign o_cursor = r_cursor;
    assign o_win    = r_win;
    assign o_lose   = r_lose;

endmodule

// File: tb/tb_tablero_ctrl.sv
// Bench for tablero_ctrl: a cell-array game model checked every cycle against
// the wrapping instance, plus literal checks on both wrap and saturate instances.
module tb_tablero_ctrl;

    logic clk = 1'b0;
    logic reset, start, up, down, left, right, reveal, flag;
    logic [63:0] mines;

    logic [63:0][3:0] states1, states2;
    logic [3:0]       state1, state2;
    logic [5:0]       cursor1, cursor2;
    logic             busy1, busy2, win1, win2, lose1, lose2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tablero_ctrl #(.MOVE_WRAP(1'b1)) u_wrap (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_mines(mines),
        .i_up(up), .i_down(down), .i_left(left), .i_right(right),
        .i_reveal(reveal), .i_flag(flag),
        .o_states(states1), .o_state(state1), .o_cursor(cursor1),
        .o_busy(busy1), .o_win(win1), .o_lose(lose1)
    );

    tablero_ctrl #(.MOVE_WRAP(1'b0)) u_sat (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_mines(mines),
        .i_up(up), .i_down(down), .i_left(left), .i_right(right),
        .i_reveal(reveal), .i_flag(flag),
        .o_states(states2), .o_state(state2), .o_cursor(cursor2),
        .o_busy(busy2), .o_win(win2), .o_lose(lose2)
    );

    // Game model: modes are "what the player can do", not RTL states
    localparam int M_IDLE = 0, M_PLAY = 1, M_REV = 2, M_SHOW = 3, M_WIN = 4, M_LOSE = 5;
    int          m_cells[64];
    logic [63:0] m_mines;
    int m_total, m_rev, m_cur, m_mode, m_tmr, m_tgt, m_pend;
    bit m_win, m_lose, m_valid = 0;

    function automatic int nbr_count(input logic [63:0] mm, input int idx);
        int r, c, n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                r = idx / 8 + dr;
                c = idx % 8 + dc;
                if ((dr != 0 || dc != 0) && r >= 0 && r < 8 && c >= 0 && c < 8 && mm[r*8+c])
                    n++;
            end
        return n;
    endfunction

    task automatic model_step();
        int row, col, pc, sc;
        if (reset) begin
            foreach (m_cells[i]) m_cells[i] = 9;
            m_mines = '0; m_total = 0; m_rev = 0; m_cur = 0; m_mode = M_IDLE;
            m_win = 0; m_lose = 0; m_valid = 1;
        end else if (start) begin
            pc = 0;
            for (int i = 0; i < 64; i++) pc += int'(mines[i]);
            foreach (m_cells[i]) m_cells[i] = 9;
            m_mines = mines; m_total = pc; m_rev = 0; m_cur = 0; m_lose = 0;
            m_win  = (pc == 64);
            m_mode = m_win ? M_WIN : M_PLAY;
        end else begin
            case (m_mode)
                M_PLAY: begin
                    row = m_cur / 8; col = m_cur % 8;
                    if (up) row = (row + 7) % 8; else if (down) row = (row + 1) % 8;
                    if (left) col = (col + 7) % 8; else if (right) col = (col + 1) % 8;
                    if (reveal && m_cells[m_cur] == 9) begin
                        if (m_mines[m_cur]) begin
                            m_cells[m_cur] = 11; m_mode = M_SHOW; m_tmr = 64;
                        end else begin
                            m_tgt = m_cur; m_pend = nbr_count(m_mines, m_cur);
                            m_mode = M_REV; m_tmr = 9;
                        end
                    end else if (!reveal && flag && m_cells[m_cur] == 9) m_cells[m_cur] = 10;
                    else if (!reveal && flag && m_cells[m_cur] == 10) m_cells[m_cur] = 9;
                    m_cur = row * 8 + col;
                end
                M_REV: begin
                    m_tmr--;
                    if (m_tmr == 0) begin
                        m_cells[m_tgt] = m_pend;
                        m_rev++;
                        if (m_rev == 64 - m_total) begin m_win = 1; m_mode = M_WIN; end
                        else m_mode = M_PLAY;
                    end
                end
                M_SHOW: begin
                    sc = 64 - m_tmr;
                    if (m_mines[sc] && (m_cells[sc] == 9 || m_cells[sc] == 10)) m_cells[sc] = 12;
                    m_tmr--;
                    if (m_tmr == 0) begin m_lose = 1; m_mode = M_LOSE; end
                end
                default: ;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic cmp(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            if (bad < 40) $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            int first_bad;
            first_bad = -1;
            for (int i = 0; i < 64; i++)
                if (first_bad < 0 && int'(states1[i]) != m_cells[i]) first_bad = i;
            cmp("model_states_first_bad_idx", first_bad, -1);
            cmp("model_state", int'(state1), m_cells[m_cur]);
            cmp("model_cursor", int'(cursor1), m_cur);
            cmp("model_busy", int'(busy1), int'(m_mode == M_REV || m_mode == M_SHOW));
            cmp("model_win", int'(win1), int'(m_win));
            cmp("model_lose", int'(lose1), int'(m_lose));
        end
    end

    task automatic act(input logic s, u, d, l, r, rv, f);
        start = s; up = u; down = d; left = l; right = r; reveal = rv; flag = f;
        @(negedge clk);
        start = 0; up = 0; down = 0; left = 0; right = 0; reveal = 0; flag = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int nbusy;
        reset = 1; start = 0; up = 0; down = 0; left = 0; right = 0; reveal = 0; flag = 0;
        mines = '0;
        tick(2);
        reset = 0;
        cmp("rst_cursor", int'(cursor1), 0);
        cmp("rst_cell5", int'(states1[5]), 9);
        cmp("rst_busy", int'(busy1), 0);
        cmp("rst_winlose", int'({win1, lose1}), 0);

        // single mine in cell 0, reveal cell 9
        mines = 64'h1;
        act(1, 0, 0, 0, 0, 0, 0);
        act(0, 0, 1, 0, 0, 0, 0);
        act(0, 0, 0, 0, 1, 0, 0);
        cmp("cursor_at_9", int'(cursor1), 9);
        act(0, 0, 0, 0, 0, 1, 0);
        nbusy = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy1) nbusy++;
            if (i == 8) begin
                cmp("cell9_hidden_while_busy", int'(states1[9]), 9);
                cmp("no_win_while_busy", int'(win1), 0);
            end
            tick(1);
        end
        cmp("busy_cycles", nbusy, 9);
        cmp("cell9_count", int'(states1[9]), 1);
        cmp("win_after_reveal", int'(win1), 0);
        cmp("sat_state_cell9", int'(state2), 1);

        // edge behaviour: wrap vs saturate
        repeat (6) act(0, 0, 0, 0, 1, 0, 0);
        act(0, 1, 0, 0, 0, 0, 0);
        cmp("cursor_at_7", int'(cursor1), 7);
        act(0, 0, 0, 0, 1, 0, 0);
        cmp("wrap_right", int'(cursor1), 0);
        cmp("sat_right", int'(cursor2), 7);
        act(0, 1, 0, 0, 0, 0, 0);
        cmp("wrap_up", int'(cursor1), 56);
        cmp("sat_up", int'(cursor2), 7);

        // flag on revealed cell, then flag+reveal on hidden safe cell
        act(0, 0, 1, 0, 0, 0, 0);
        act(0, 0, 1, 0, 0, 0, 0);
        act(0, 0, 0, 0, 1, 0, 0);
        act(0, 0, 0, 0, 0, 0, 1);
        cmp("flag_on_revealed", int'(states1[9]), 1);
        act(0, 0, 0, 0, 1, 0, 0);
        act(0, 0, 0, 0, 0, 1, 1);
        cmp("reveal_beats_flag_pending", int'(states1[10]), 9);
        tick(11);
        cmp("reveal_beats_flag_final", int'(states1[10]), 0);

        // start aborts a COUNT
        act(0, 0, 0, 0, 1, 0, 0);
        act(0, 0, 0, 0, 0, 1, 0);
        tick(3);
        act(1, 0, 0, 0, 0, 0, 0);
        cmp("restart_cell9", int'(states1[9]), 9);
        cmp("restart_cursor", int'(cursor1), 0);
        cmp("restart_busy", int'(busy1), 0);

        // mines at 0 and 63: flag 63, explode 0, show sweep
        mines = 64'h8000_0000_0000_0001;
        act(1, 0, 0, 0, 0, 0, 0);
        act(0, 1, 0, 0, 0, 0, 0);
        act(0, 0, 0, 1, 0, 0, 0);
        cmp("cursor_at_63", int'(cursor1), 63);
        act(0, 0, 0, 0, 0, 0, 1);
        cmp("flag63", int'(states1[63]), 10);
        act(0, 0, 1, 0, 0, 0, 0);
        act(0, 0, 0, 0, 1, 0, 0);
        act(0, 0, 0, 0, 0, 1, 0);
        cmp("exploded0", int'(states1[0]), 11);
        cmp("show_busy", int'(busy1), 1);
        tick(63);
        cmp("lose_not_yet", int'(lose1), 0);
        cmp("cell63_not_yet", int'(states1[63]), 10);
        tick(1);
        cmp("cell63_shown", int'(states1[63]), 12);
        cmp("lose_set", int'(lose1), 1);
        cmp("win_clear_on_lose", int'(win1), 0);
        act(0, 0, 0, 0, 0, 0, 1);
        act(0, 0, 0, 0, 0, 1, 0);
        act(0, 0, 0, 0, 1, 0, 0);
        cmp("lose_frozen_cursor", int'(cursor1), 0);
        cmp("lose_frozen_cell0", int'(states1[0]), 11);

        // reset in the middle of SHOW
        act(1, 0, 0, 0, 0, 0, 0);
        act(0, 0, 0, 0, 0, 1, 0);
        tick(5);
        reset = 1;
        tick(1);
        reset = 0;
        cmp("rst_show_lose", int'(lose1), 0);
        cmp("rst_show_busy", int'(busy1), 0);
        cmp("rst_show_cell0", int'(states1[0]), 9);
        act(0, 0, 0, 0, 1, 0, 0);
        cmp("idle_no_move", int'(cursor1), 0);

        // every cell a mine except 27: single reveal wins
        mines = ~(64'd1 << 27);
        act(1, 0, 0, 0, 0, 0, 0);
        repeat (3) act(0, 0, 1, 0, 1, 0, 0);
        cmp("diag_move_27", int'(cursor1), 27);
        act(0, 0, 0, 0, 0, 1, 0);
        tick(8);
        cmp("win_pending", int'(win1), 0);
        tick(2);
        cmp("cell27_eight", int'(states1[27]), 8);
        cmp("win_set", int'(win1), 1);
        cmp("lose_clear_on_win", int'(lose1), 0);

        // full board of mines: immediate win
        mines = '1;
        act(1, 0, 0, 0, 0, 0, 0);
        cmp("all_mines_win", int'(win1), 1);
        cmp("all_mines_sat_win", int'(win2), 1);
        cmp("all_mines_sat_lose", int'(lose2), 0);
        act(0, 0, 0, 0, 0, 1, 0);
        cmp("win_reveal_ignored", int'(states1[0]), 9);
        cmp("win_sat_busy", int'(busy2), 0);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
